cmd_parser: RTL and testbench

- Synthesizable byte-stream command decoder that sits directly upstream of the command handler.
- Accepts raw serial bytes (post-UART), recognises single-character command codes and collects the fixed-length little-endian argument each one carries.
- Presents one decoded {cmd, arg} record per command over a valid/ready handshake.
- Abandoned argument transfers time out and are reported as the 8'hFF timeout command.

---
 rtl/cmd_pkg.sv | 54 +++++
 rtl/cmd_parser_if.sv | 25 ++
 rtl/cmd_timeout_counter.sv | 28 ++
 rtl/cmd_parser.sv | 125 ++++++++++++
 tb/tb_cmd_parser.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/cmd_pkg.sv
// Command-code table shared by the byte-stream parser, the command handler and host-protocol tests.
// cmd_arg_len() is the single source of truth for which codes exist and how many argument bytes follow.
package cmd_pkg;

    localparam logic [7:0] CMD_ADDR_W  = 8'h41; // 'A'
    localparam logic [7:0] CMD_BYTE_W  = 8'h42; // 'B'
    localparam logic [7:0] CMD_OFFSET  = 8'h4F; // 'O'
    localparam logic [7:0] CMD_MASK    = 8'h4D; // 'M'
    localparam logic [7:0] CMD_READ    = 8'h72; // 'r'
    localparam logic [7:0] CMD_INFO    = 8'h49; // 'I'
    localparam logic [7:0] CMD_ARM     = 8'h61; // 'a'
    localparam logic [7:0] CMD_BREAK   = 8'h62; // 'b'
    localparam logic [7:0] CMD_STATUS  = 8'h73; // 's'
    localparam logic [7:0] CMD_FLUSH   = 8'h66; // 'f'
    localparam logic [7:0] CMD_NOP     = 8'h4E; // 'N'
    localparam logic [7:0] CMD_CLEAR   = 8'h63; // 'c'
    localparam logic [7:0] CMD_CAPTURE = 8'h43; // 'C'
    localparam logic [7:0] CMD_TRIGGER = 8'h54; // 'T'
    localparam logic [7:0] CMD_RUN     = 8'h52; // 'R'
    localparam logic [7:0] CMD_ZERO    = 8'h5A; // 'Z'
    localparam logic [7:0] CMD_QUIT    = 8'h51; // 'Q'
    localparam logic [7:0] CMD_TIMEOUT = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARG,
        ST_OUT
    } cmd_state_t;

    typedef struct packed {
        logic [7:0]  cmd;
        logic [31:0] arg;
        logic [2:0]  arg_len;
        logic        err_unknown;
    } cmd_rec_t;

    localparam cmd_rec_t CMD_TIMEOUT_REC = '{cmd: CMD_TIMEOUT, arg: 32'd0, arg_len: 3'd0, err_unknown: 1'b0};

    // Returns {known, len}; unknown codes carry no argument.
    function automatic logic [3:0] cmd_arg_len(input logic [7:0] code);
        logic [3:0] r;
        case (code)
            CMD_ADDR_W:                     r = 4'b1_010;
            CMD_BYTE_W:                     r = 4'b1_001;
            CMD_OFFSET, CMD_MASK, CMD_READ: r = 4'b1_100;
            CMD_INFO, CMD_ARM, CMD_BREAK, CMD_STATUS, CMD_FLUSH, CMD_NOP,
            CMD_CLEAR, CMD_CAPTURE, CMD_TRIGGER, CMD_RUN, CMD_ZERO, CMD_QUIT,
            CMD_TIMEOUT:                    r = 4'b1_000;
            default:                        r = 4'b0_000;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/cmd_parser_if.sv
// Byte-in / record-out bus of the command parser.
// master = byte source and record consumer, slave = the parser itself.
interface cmd_parser_if;

    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  cmd;
    logic [31:0] arg;
    logic [2:0]  arg_len;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        err_unknown;

    modport master (
        output rx_data, rx_valid, cmd_ready,
        input  rx_ready, cmd, arg, arg_len, cmd_valid, err_unknown
    );

    modport slave (
        input  rx_data, rx_valid, cmd_ready,
        output rx_ready, cmd, arg, arg_len, cmd_valid, err_unknown
    );

endinterface

// File: rtl/cmd_timeout_counter.sv
// Saturating idle-cycle counter: counts while enabled, clear has priority, expire flags the limit.
// expire is only asserted in a cycle where the counter is enabled, so a clear in the same cycle wins.
module cmd_timeout_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] limit,
    output logic             expire
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expire = en && (cnt == limit);

endmodule

// File: rtl/cmd_parser.sv
// Byte-stream command decoder: command code + little-endian argument -> one {cmd, arg} record.
// Define CMD_IDLE_TIMEOUT_EN to also emit 8'hFF records after TIMEOUT_CYCLES idle cycles in IDLE.
module cmd_parser
    import cmd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int CNT_W          = 32
) (
    input  logic        clk,
    input  logic        rst,
    cmd_parser_if.slave bus
);

    localparam logic [CNT_W-1:0] TMO_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    cmd_state_t state, state_nxt;
    cmd_rec_t   rec;
    logic [1:0] byte_idx;
    logic [3:0] lookup;
    logic       xfer, last_byte;
    logic       tmo_clr, tmo_en, tmo_exp;

    assign xfer      = bus.rx_valid && bus.rx_ready;
    assign lookup    = cmd_arg_len(bus.rx_data);
    assign last_byte = ({1'b0, byte_idx} == (rec.arg_len - 3'd1));

    // Counter runs only while waiting for bytes; any accepted byte restarts it.
    always_comb begin
        tmo_clr = 1'b1;
        tmo_en  = 1'b0;
        case (state)
            ST_ARG: begin
                tmo_clr = xfer;
                tmo_en  = !xfer;
            end
`ifdef CMD_IDLE_TIMEOUT_EN
            ST_IDLE: begin
                tmo_clr = xfer;
                tmo_en  = !xfer;
            end
`else
            ST_IDLE: begin
                tmo_clr = 1'b1;
                tmo_en  = 1'b0;
            end
`endif
            default: ;
        endcase
    end

    cmd_timeout_counter #(
        .CNT_W (CNT_W)
    ) u_tmo (
        .clk    (clk),
        .rst    (rst),
        .clr    (tmo_clr),
        .en     (tmo_en),
        .limit  (TMO_LIMIT),
        .expire (tmo_exp)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (xfer)         state_nxt = (lookup[2:0] == 3'd0) ? ST_OUT : ST_ARG;
                else if (tmo_exp) state_nxt = ST_OUT;
            end
            ST_ARG: begin
                if ((xfer && last_byte) || tmo_exp) state_nxt = ST_OUT;
            end
            ST_OUT: begin
                if (bus.cmd_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // rx_ready is gated by rst so no byte is taken while reset is held.
    always_comb begin
        bus.rx_ready    = rst && (state != ST_OUT);
        bus.cmd_valid   = (state == ST_OUT);
        bus.cmd         = rec.cmd;
        bus.arg         = rec.arg;
        bus.arg_len     = rec.arg_len;
        bus.err_unknown = rec.err_unknown;
    end

    // Record only changes in IDLE/ARG, so it is stable for the whole of OUT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rec      <= '0;
            byte_idx <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (xfer) begin
                        rec.cmd         <= bus.rx_data;
                        rec.arg         <= '0;
                        rec.arg_len     <= lookup[2:0];
                        rec.err_unknown <= !lookup[3];
                        byte_idx        <= '0;
                    end else if (tmo_exp) begin
                        rec <= CMD_TIMEOUT_REC;
                    end
                end
                ST_ARG: begin
                    if (xfer) begin
                        rec.arg[{byte_idx, 3'b000} +: 8] <= bus.rx_data;
                        byte_idx                          <= byte_idx + 2'd1;
                    end else if (tmo_exp) begin
                        rec <= CMD_TIMEOUT_REC;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cmd_parser.sv
// Scoreboard bench for cmd_parser: stimulus pushes expected records, a monitor pops them on each handshake.
// With CMD_IDLE_TIMEOUT_EN defined only the idle-timeout scenario runs.
module tb_cmd_parser;
    import cmd_pkg::*;

    localparam int TMO = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    cmd_parser_if bus();

    cmd_parser #(
        .TIMEOUT_CYCLES (TMO),
        .CNT_W          (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    cmd_rec_t exp_q[$];
    cmd_rec_t mon_got, mon_want;
    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", name, got, want);
        end
    endtask

    task automatic expect_rec(input logic [7:0] c, input logic [31:0] a, input logic [2:0] l, input logic e);
        exp_q.push_back('{cmd: c, arg: a, arg_len: l, err_unknown: e});
    endtask

    // Called just after a posedge; returns just after the posedge that accepted the byte.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(negedge clk);
        while (!bus.rx_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (!bus.rx_ready) begin
            total++;
            bad++;
            $display("FAIL send_byte %h: rx_ready never rose", b);
        end
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst && bus.cmd_valid && bus.cmd_ready) begin
            mon_got = '{cmd: bus.cmd, arg: bus.arg, arg_len: bus.arg_len, err_unknown: bus.err_unknown};
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL record: unexpected cmd=%h arg=%h len=%0d err=%b",
                         mon_got.cmd, mon_got.arg, mon_got.arg_len, mon_got.err_unknown);
            end else begin
                mon_want = exp_q.pop_front();
                if (mon_got !== mon_want) begin
                    bad++;
                    $display("FAIL record: got cmd=%h arg=%h len=%0d err=%b want cmd=%h arg=%h len=%0d err=%b",
                             mon_got.cmd, mon_got.arg, mon_got.arg_len, mon_got.err_unknown,
                             mon_want.cmd, mon_want.arg, mon_want.arg_len, mon_want.err_unknown);
                end
            end
        end
    end

    initial begin
        int n;
        bus.rx_data   = 8'h00;
        bus.rx_valid  = 1'b0;
        bus.cmd_ready = 1'b1;
        rst           = 1'b0;

        repeat (3) @(negedge clk);
        check("reset rx_ready",    {31'd0, bus.rx_ready},    32'd0);
        check("reset cmd_valid",   {31'd0, bus.cmd_valid},   32'd0);
        check("reset cmd",         {24'd0, bus.cmd},         32'd0);
        check("reset arg",         bus.arg,                  32'd0);
        check("reset arg_len",     {29'd0, bus.arg_len},     32'd0);
        check("reset err_unknown", {31'd0, bus.err_unknown}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("rx_ready after reset", {31'd0, bus.rx_ready}, 32'd1);
        @(posedge clk); #1;

`ifdef CMD_IDLE_TIMEOUT_EN
        expect_rec(8'hFF, 32'd0, 3'd0, 1'b0);
        expect_rec(8'hFF, 32'd0, 3'd0, 1'b0);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.cmd_valid && bus.cmd_ready) n++;
        end
        check("idle timeout records", n, 32'd2);
`else
        // Idle in IDLE: no timeout records without the idle feature
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.cmd_valid) n++;
        end
        check("no idle records", n, 32'd0);
        @(posedge clk); #1;

        // 'I': zero-length command, valid the cycle after the transfer
        expect_rec(8'h49, 32'd0, 3'd0, 1'b0);
        send_byte(8'h49);
        @(negedge clk);
        check("I latency cmd_valid", {31'd0, bus.cmd_valid}, 32'd1);
        check("I rx_ready in OUT",   {31'd0, bus.rx_ready},  32'd0);
        @(posedge clk); #1;

        // 'A' 34 12 with the consumer stalled for 3 cycles
        expect_rec(8'h41, 32'h0000_1234, 3'd2, 1'b0);
        bus.cmd_ready = 1'b0;
        send_byte(8'h41);
        send_byte(8'h34);
        send_byte(8'h12);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("A rx_ready held low", {31'd0, bus.rx_ready},  32'd0);
            check("A cmd_valid",         {31'd0, bus.cmd_valid}, 32'd1);
        end
        @(posedge clk); #1;
        bus.cmd_ready = 1'b1;
        @(posedge clk); #1;

        // 'M' 78 56 34 12 stalled 10 cycles while 'c' waits at the input
        expect_rec(8'h4D, 32'h1234_5678, 3'd4, 1'b0);
        expect_rec(8'h63, 32'd0, 3'd0, 1'b0);
        bus.cmd_ready = 1'b0;
        send_byte(8'h4D);
        send_byte(8'h78);
        send_byte(8'h56);
        send_byte(8'h34);
        send_byte(8'h12);
        bus.rx_data  = 8'h63;
        bus.rx_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("M stable cmd",      {24'd0, bus.cmd},        32'h4D);
            check("M stable arg",      bus.arg,                 32'h1234_5678);
            check("M stable valid",    {31'd0, bus.cmd_valid},  32'd1);
            check("M c not accepted",  {31'd0, bus.rx_ready},   32'd0);
        end
        @(posedge clk); #1;
        bus.cmd_ready = 1'b1;
        n = 0;
        @(negedge clk);
        while (!bus.rx_ready && n < 20) begin
            n++;
            @(negedge clk);
        end
        check("rx_ready rise delay",            n, 32'd1);
        check("cmd_valid low when rx_ready up", {31'd0, bus.cmd_valid}, 32'd0);
        @(posedge clk); #1;
        bus.rx_valid = 1'b0;
        @(posedge clk); #1;

        // 'B' then silence: timeout record after TMO idle ARG cycles
        expect_rec(8'hFF, 32'd0, 3'd0, 1'b0);
        send_byte(8'h42);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.cmd_valid && n < 50);
        check("timeout latency", n, 32'd9);
        @(posedge clk); #1;

        // 'B' with its byte on the limit cycle: byte wins
        expect_rec(8'h42, 32'h0000_00A5, 3'd1, 1'b0);
        send_byte(8'h42);
        repeat (7) @(posedge clk);
        #1;
        send_byte(8'hA5);
        @(negedge clk);
        check("limit-cycle byte cmd", {24'd0, bus.cmd}, 32'h42);
        @(posedge clk); #1;

        // Unknown code
        expect_rec(8'h58, 32'd0, 3'd0, 1'b1);
        send_byte(8'h58);
        @(negedge clk);
        @(posedge clk); #1;

        // 'I' byte inside an 'M' argument is data
        expect_rec(8'h4D, 32'h0000_0049, 3'd4, 1'b0);
        send_byte(8'h4D);
        send_byte(8'h49);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        @(negedge clk);
        @(posedge clk); #1;

        // Reset mid-ARG drops the partial 'O', then 'N' decodes cleanly
        send_byte(8'h4F);
        send_byte(8'h01);
        send_byte(8'h02);
        rst = 1'b0;
        @(negedge clk);
        check("mid-reset cmd_valid", {31'd0, bus.cmd_valid}, 32'd0);
        check("mid-reset rx_ready",  {31'd0, bus.rx_ready},  32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        expect_rec(8'h4E, 32'd0, 3'd0, 1'b0);
        send_byte(8'h4E);
`endif

        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            n++;
            @(negedge clk);
        end
        check("scoreboard drained", exp_q.size(), 32'd0);
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
